// File: rtl/simple_bus_ram_model_if.sv
// -----------------------------------------------------------------------------
// simple_bus_ram_model_if
//
// Purpose: groups the icache and dcache simple-bus command/response signals
// that connect the CPU (master) to the RAM model (slave).
//
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high. cmd_ready never depends on cmd_valid. Responses
// have no ready; a rsp_valid pulse is one cycle long and must be taken then.
//
// Signals:
//   icache_cmd_valid/ready, icache_cmd_payload_addr   fetch command
//   icache_rsp_valid, icache_rsp_payload_data         fetch response
//   dcache_cmd_valid/ready, dcache_cmd_payload_addr,
//   dcache_cmd_payload_wen/wdata/wstrb                data command
//   dcache_rsp_valid, dcache_rsp_payload_data         data response
// -----------------------------------------------------------------------------
interface simple_bus_ram_model_if #(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int I_DATA_W = 32
);
   logic                  icache_cmd_valid;
   logic                  icache_cmd_ready;
   logic [ADDR_W-1:0]     icache_cmd_payload_addr;
   logic                  icache_rsp_valid;
   logic [I_DATA_W-1:0]   icache_rsp_payload_data;

   logic                  dcache_cmd_valid;
   logic                  dcache_cmd_ready;
   logic [ADDR_W-1:0]     dcache_cmd_payload_addr;
   logic                  dcache_cmd_payload_wen;
   logic [DATA_W-1:0]     dcache_cmd_payload_wdata;
   logic [DATA_W/8-1:0]   dcache_cmd_payload_wstrb;
   logic                  dcache_rsp_valid;
   logic [DATA_W-1:0]     dcache_rsp_payload_data;

   modport master (
      output icache_cmd_valid, icache_cmd_payload_addr,
      input  icache_cmd_ready, icache_rsp_valid, icache_rsp_payload_data,
      output dcache_cmd_valid, dcache_cmd_payload_addr, dcache_cmd_payload_wen,
      output dcache_cmd_payload_wdata, dcache_cmd_payload_wstrb,
      input  dcache_cmd_ready, dcache_rsp_valid, dcache_rsp_payload_data
   );

   modport slave (
      input  icache_cmd_valid, icache_cmd_payload_addr,
      output icache_cmd_ready, icache_rsp_valid, icache_rsp_payload_data,
      input  dcache_cmd_valid, dcache_cmd_payload_addr, dcache_cmd_payload_wen,
      input  dcache_cmd_payload_wdata, dcache_cmd_payload_wstrb,
      output dcache_cmd_ready, dcache_rsp_valid, dcache_rsp_payload_data
   );
endinterface

// File: rtl/simple_bus_ram_model.sv
// -----------------------------------------------------------------------------
// simple_bus_ram_model
//
// Purpose: dual-port memory model for the core's icache/dcache simple-bus
// ports. One shared word array, a read-only instruction port returning an
// I_DATA_W slice, a data port with byte-strobed writes, a fixed response
// latency per port and a periodic command back-pressure pattern.
//
// Ports:
//   clk    in  sole clock, rising edge
//   rst_n  in  asynchronous active-low reset (pipelines and stall counter only;
//              memory contents survive reset)
//   bus    slave modport of simple_bus_ram_model_if (all command/response
//          signals of both ports)
//
// Build option:
//   SIMPLE_BUS_RAM_WRITE_RSP_EN  when defined, an accepted dcache write also
//                                returns a response carrying the word value
//                                from before the write. When undefined only
//                                reads respond.
// -----------------------------------------------------------------------------
module simple_bus_ram_model #(
   parameter int    DATA_W       = 64,
   parameter int    I_DATA_W     = 32,
   parameter int    ADDR_W       = 64,
   parameter int    DEPTH        = 1024,
   parameter int    I_LATENCY    = 1,
   parameter int    D_LATENCY    = 1,
   parameter int    STALL_PERIOD = 0,
   parameter int    STALL_CYCLES = 0,
   parameter string INIT_FILE    = ""
) (
   input  logic                   clk,
   input  logic                   rst_n,
   simple_bus_ram_model_if.slave  bus
);

   localparam int BYTES   = DATA_W / 8;
   localparam int OFF_W   = $clog2(BYTES);
   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int I_OFF_W = $clog2(I_DATA_W / 8);
   localparam int N_SLICE = DATA_W / I_DATA_W;
   localparam int SL_W    = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
   localparam int CNT_W   = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

   // ---------------------------------------------------------------- storage
   logic [DATA_W-1:0] mem_q [DEPTH];

   // ---------------------------------------------------------- stall counter
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             stalled;
   logic             cmd_ready;

   generate
      if (STALL_PERIOD > 1) begin : g_cnt
         assign stall_cnt_d = (stall_cnt_q == CNT_W'(STALL_PERIOD - 1)) ? '0
                                                                        : stall_cnt_q + 1'b1;
      end else begin : g_no_cnt
         assign stall_cnt_d = '0;
      end

      if (STALL_CYCLES > 0) begin : g_stall
         assign stalled = (stall_cnt_q < CNT_W'(STALL_CYCLES));
      end else begin : g_no_stall
         assign stalled = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   // Ready is a function of the counter and reset only, so no input-to-output
   // combinational path exists through cmd_valid.
   assign cmd_ready            = rst_n & ~stalled;
   assign bus.icache_cmd_ready = cmd_ready;
   assign bus.dcache_cmd_ready = cmd_ready;

   // -------------------------------------------------------- address decode
   logic                 i_acc, d_acc, d_wr, d_rsp_req;
   logic [IDX_W-1:0]     i_idx, d_idx;
   logic [SL_W-1:0]      i_sl;
   logic [DATA_W-1:0]    i_word, d_word, wmask, d_wr_word;
   logic [I_DATA_W-1:0]  i_slice;

   assign i_acc = bus.icache_cmd_valid & cmd_ready;
   assign d_acc = bus.dcache_cmd_valid & cmd_ready;
   assign d_wr  = d_acc & bus.dcache_cmd_payload_wen;

   // Truncating casts drop the upper address bits, wrapping modulo DEPTH.
   assign i_idx = IDX_W'(bus.icache_cmd_payload_addr >> OFF_W);
   assign d_idx = IDX_W'(bus.dcache_cmd_payload_addr >> OFF_W);
   assign i_sl  = (N_SLICE > 1) ? SL_W'(bus.icache_cmd_payload_addr >> I_OFF_W) : '0;

   // Reads use the array value before this edge's write, so a same-edge
   // icache fetch of a word being written returns the old contents.
   assign i_word = mem_q[i_idx];
   assign d_word = mem_q[d_idx];

   always_comb begin
      i_slice = '0;
      for (int s = 0; s < N_SLICE; s++) begin
         if (i_sl == SL_W'(s)) i_slice = i_word[s*I_DATA_W +: I_DATA_W];
      end
   end

   always_comb begin
      wmask = '0;
      for (int b = 0; b < BYTES; b++) begin
         wmask[b*8 +: 8] = {8{bus.dcache_cmd_payload_wstrb[b]}};
      end
   end

   assign d_wr_word = (bus.dcache_cmd_payload_wdata & wmask) | (d_word & ~wmask);

   always_ff @(posedge clk) begin
      if (d_wr) mem_q[d_idx] <= d_wr_word;
   end

`ifdef SIMPLE_BUS_RAM_WRITE_RSP_EN
   assign d_rsp_req = d_acc;
`else
   assign d_rsp_req = d_acc & ~bus.dcache_cmd_payload_wen;
`endif

   // -------------------------------------------------- response pipelines
   // Stage 0 captures at the accept edge N; stage LATENCY is driven out, so
   // rsp_valid rises at edge N+LATENCY and lasts exactly one cycle.
   logic [I_LATENCY:0]  i_v_q, i_v_d;
   logic [I_DATA_W-1:0] i_d_q [I_LATENCY+1];
   logic [D_LATENCY:0]  d_v_q, d_v_d;
   logic [DATA_W-1:0]   d_d_q [D_LATENCY+1];

   assign i_v_d = {i_v_q[I_LATENCY-1:0], i_acc};
   assign d_v_d = {d_v_q[D_LATENCY-1:0], d_rsp_req};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_v_q <= '0;
         for (int k = 0; k <= I_LATENCY; k++) i_d_q[k] <= '0;
      end else begin
         i_v_q    <= i_v_d;
         i_d_q[0] <= i_slice;
         for (int k = 1; k <= I_LATENCY; k++) i_d_q[k] <= i_d_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_v_q <= '0;
         for (int k = 0; k <= D_LATENCY; k++) d_d_q[k] <= '0;
      end else begin
         d_v_q    <= d_v_d;
         d_d_q[0] <= d_word;
         for (int k = 1; k <= D_LATENCY; k++) d_d_q[k] <= d_d_q[k-1];
      end
   end

   assign bus.icache_rsp_valid        = i_v_q[I_LATENCY];
   assign bus.icache_rsp_payload_data = i_d_q[I_LATENCY];
   assign bus.dcache_rsp_valid        = d_v_q[D_LATENCY];
   assign bus.dcache_rsp_payload_data = d_d_q[D_LATENCY];

endmodule
